// File: rtl/mem_if_pkg.sv
// Shared definitions for the line/burst memory interface.
//
// Contents:
//   adaptor_state_t      - control states of the line-to-burst adaptor
//   DEF_ADDR_WIDTH       - default address width
//   DEF_LINE_WIDTH       - default cache line width in bits
//   DEF_BEAT_WIDTH       - default burst beat width in bits
//   line_offset_bits()   - number of byte-offset address bits inside one line
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } adaptor_state_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_WIDTH = 256;
    localparam int DEF_BEAT_WIDTH = 64;

    // Byte-offset bits covered by one line (5 for a 256-bit line).
    function automatic int line_offset_bits(input int line_width);
        return $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/line_burst_adaptor.sv
// Line-to-burst adaptor: memory-side responder for the write buffer's line port.
// A whole-line read or write request is turned into a fixed-length burst of
// BEAT_WIDTH-bit beats on the physical memory interface; read beats are
// reassembled into a line and a single completion pulse is returned.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   line_read_i     - line read request, held until line_resp_o
//   line_write_i    - line write request, held until line_resp_o
//   line_addr_i     - line address (offset bits ignored)
//   line_wdata_i    - line write data
//   line_rdata_o    - assembled read line, held until the next read overwrites it
//   line_resp_o     - one-cycle completion pulse
//   burst_addr_o    - line-aligned burst address (0 when idle)
//   burst_read_o    - burst read request
//   burst_write_o   - burst write request
//   burst_wdata_o   - current write beat (0 when not writing)
//   burst_rdata_i   - current read beat
//   burst_resp_i    - beat accepted (write) / beat valid (read)
//
// BEATS = LINE_WIDTH / BEAT_WIDTH must be a power of two so the beat counter
// wraps to 0 exactly on the last beat.
module line_burst_adaptor
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_read_i,
    input  logic                  line_write_i,
    input  logic [ADDR_WIDTH-1:0] line_addr_i,
    input  logic [LINE_WIDTH-1:0] line_wdata_i,
    output logic [LINE_WIDTH-1:0] line_rdata_o,
    output logic                  line_resp_o,
    output logic [ADDR_WIDTH-1:0] burst_addr_o,
    output logic                  burst_read_o,
    output logic                  burst_write_o,
    output logic [BEAT_WIDTH-1:0] burst_wdata_o,
    input  logic [BEAT_WIDTH-1:0] burst_rdata_i,
    input  logic                  burst_resp_i
);

    localparam int BEATS    = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_BITS = line_offset_bits(LINE_WIDTH);

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFF_BITS;

    adaptor_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Write line is kept as beat slots so the current beat is a plain index.
    logic [BEAT_WIDTH-1:0] wbuf_q [BEATS];
    logic [BEAT_WIDTH-1:0] rbuf_q [BEATS];

    logic load_wbuf;
    logic store_rbeat;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        load_wbuf     = 1'b0;
        store_rbeat   = 1'b0;
        line_resp_o   = 1'b0;
        burst_read_o  = 1'b0;
        burst_write_o = 1'b0;
        burst_addr_o  = '0;
        burst_wdata_o = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Read has priority; a simultaneous write is dropped and must
                // be re-requested by the line requester.
                if (line_read_i) begin
                    addr_d  = line_addr_i & ADDR_MASK;
                    cnt_d   = '0;
                    state_d = ST_READ;
                end else if (line_write_i) begin
                    addr_d    = line_addr_i & ADDR_MASK;
                    cnt_d     = '0;
                    load_wbuf = 1'b1;
                    state_d   = ST_WRITE;
                end
            end

            ST_READ: begin
                burst_read_o = 1'b1;
                burst_addr_o = addr_q;
                if (burst_resp_i) begin
                    store_rbeat = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_WRITE: begin
                burst_write_o = 1'b1;
                burst_addr_o  = addr_q;
                burst_wdata_o = wbuf_q[cnt_q];
                if (burst_resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Requests are not sampled here, so the held request cannot
                // be accepted a second time.
                line_resp_o = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: reset clears any partially transferred line
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BEATS; i++) begin
                wbuf_q[i] <= '0;
                rbuf_q[i] <= '0;
            end
        end else begin
            if (load_wbuf) begin
                for (int i = 0; i < BEATS; i++) begin
                    wbuf_q[i] <= line_wdata_i[i*BEAT_WIDTH +: BEAT_WIDTH];
                end
            end
            if (store_rbeat) begin
                rbuf_q[cnt_q] <= burst_rdata_i;
            end
        end
    end

    // Beat 0 occupies the least-significant bits of the line.
    for (genvar g = 0; g < BEATS; g++) begin : g_rdata
        assign line_rdata_o[g*BEAT_WIDTH +: BEAT_WIDTH] = rbuf_q[g];
    end

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;

    logic         clk;
    logic         rst;
    logic         line_read_i;
    logic         line_write_i;
    logic [31:0]  line_addr_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  burst_addr_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic [63:0]  burst_wdata_o;
    logic [63:0]  burst_rdata_i;
    logic         burst_resp_i;

    int checks;
    int fails;

    line_burst_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_read_i   (line_read_i),
        .line_write_i  (line_write_i),
        .line_addr_i   (line_addr_i),
        .line_wdata_i  (line_wdata_i),
        .line_rdata_o  (line_rdata_o),
        .line_resp_o   (line_resp_o),
        .burst_addr_o  (burst_addr_o),
        .burst_read_o  (burst_read_o),
        .burst_write_o (burst_write_o),
        .burst_wdata_o (burst_wdata_o),
        .burst_rdata_i (burst_rdata_i),
        .burst_resp_i  (burst_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({line_resp_o, burst_read_o, burst_write_o} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000", {line_resp_o, burst_read_o, burst_write_o});
        end
        checks++;
        if (burst_addr_o !== 32'h0 || burst_wdata_o !== 64'h0) begin
            fails++;
            $display("FAIL reset_burst: addr %h wdata %h want 0", burst_addr_o, burst_wdata_o);
        end
        checks++;
        if (line_rdata_o !== 256'h0) begin
            fails++;
            $display("FAIL reset_rdata: got %h want 0", line_rdata_o);
        end
    endtask

    task automatic test_read_b2b();
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        // cycle 0
        line_addr_i = 32'h0000_1234;
        line_read_i = 1'b1;
        checks++;
        if (burst_read_o !== 1'b0) begin
            fails++;
            $display("FAIL rd_cycle0: burst_read_o %b want 0", burst_read_o);
        end
        step();
        // cycles 1..4
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (burst_read_o !== 1'b1 || burst_addr_o !== 32'h0000_1220 || line_resp_o !== 1'b0) begin
                fails++;
                $display("FAIL rd_beat%0d: read %b addr %h resp %b want 1 00001220 0",
                         b, burst_read_o, burst_addr_o, line_resp_o);
            end
            burst_rdata_i = beats[b];
            burst_resp_i  = 1'b1;
            step();
        end
        // cycle 5
        burst_resp_i = 1'b0;
        checks++;
        if (line_resp_o !== 1'b1 || burst_read_o !== 1'b0) begin
            fails++;
            $display("FAIL rd_done: resp %b read %b want 1 0", line_resp_o, burst_read_o);
        end
        checks++;
        if (line_rdata_o !== exp_line) begin
            fails++;
            $display("FAIL rd_data: got %h want %h", line_rdata_o, exp_line);
        end
        line_read_i = 1'b0;
        step();
        checks++;
        if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || line_rdata_o !== exp_line) begin
            fails++;
            $display("FAIL rd_after: resp %b read %b data %h", line_resp_o, burst_read_o, line_rdata_o);
        end
    endtask

    task automatic test_write();
        logic [255:0] wd;
        logic [255:0] prev_rdata;
        int           nresp;
        wd = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        prev_rdata   = line_rdata_o;
        nresp        = 0;
        line_addr_i  = 32'h8000_0040;
        line_wdata_i = wd;
        line_write_i = 1'b1;
        step();
        // Changes after acceptance must be ignored.
        line_addr_i  = 32'hFFFF_FFFF;
        line_wdata_i = ~wd;
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (burst_write_o !== 1'b1 || burst_read_o !== 1'b0 || burst_addr_o !== 32'h8000_0040) begin
                fails++;
                $display("FAIL wr_ctrl%0d: write %b read %b addr %h want 1 0 80000040",
                         b, burst_write_o, burst_read_o, burst_addr_o);
            end
            checks++;
            if (burst_wdata_o !== wd[b*64 +: 64]) begin
                fails++;
                $display("FAIL wr_beat%0d: got %h want %h", b, burst_wdata_o, wd[b*64 +: 64]);
            end
            if (line_resp_o === 1'b1) nresp++;
            burst_resp_i = 1'b1;
            step();
        end
        burst_resp_i = 1'b0;
        if (line_resp_o === 1'b1) nresp++;
        checks++;
        if (burst_write_o !== 1'b0) begin
            fails++;
            $display("FAIL wr_beats: burst_write_o %b after 4 beats want 0", burst_write_o);
        end
        line_write_i = 1'b0;
        step();
        if (line_resp_o === 1'b1) nresp++;
        step();
        if (line_resp_o === 1'b1) nresp++;
        checks++;
        if (nresp != 1) begin
            fails++;
            $display("FAIL wr_resp_count: got %0d want 1", nresp);
        end
        checks++;
        if (line_rdata_o !== prev_rdata) begin
            fails++;
            $display("FAIL wr_rdata_hold: got %h want %h", line_rdata_o, prev_rdata);
        end
    endtask

    task automatic test_stalled_read();
        int           gaps [4];
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        gaps[0] = 0; gaps[1] = 3; gaps[2] = 1; gaps[3] = 5;
        beats[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        beats[1] = 64'h5555_5555_5555_5555;
        beats[2] = 64'hDEAD_BEEF_DEAD_BEEF;
        beats[3] = 64'hCAFE_F00D_CAFE_F00D;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        line_addr_i = 32'h0000_0100;
        line_read_i = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                burst_resp_i  = 1'b0;
                burst_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
                checks++;
                if (burst_read_o !== 1'b1 || line_resp_o !== 1'b0) begin
                    fails++;
                    $display("FAIL st_gap%0d_%0d: read %b resp %b want 1 0", b, g, burst_read_o, line_resp_o);
                end
                step();
            end
            checks++;
            if (burst_read_o !== 1'b1 || line_resp_o !== 1'b0) begin
                fails++;
                $display("FAIL st_beat%0d: read %b resp %b want 1 0", b, burst_read_o, line_resp_o);
            end
            burst_rdata_i = beats[b];
            burst_resp_i  = 1'b1;
            step();
        end
        burst_resp_i = 1'b0;
        checks++;
        if (line_resp_o !== 1'b1 || line_rdata_o !== exp_line) begin
            fails++;
            $display("FAIL st_done: resp %b data %h want 1 %h", line_resp_o, line_rdata_o, exp_line);
        end
        line_read_i = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        int nresp;
        int nwrite;
        nresp  = 0;
        nwrite = 0;
        line_addr_i  = 32'h0000_0040;
        line_wdata_i = {4{64'hFFFF_0000_FFFF_0000}};
        line_read_i  = 1'b1;
        line_write_i = 1'b1;
        step();
        checks++;
        if (burst_read_o !== 1'b1) begin
            fails++;
            $display("FAIL sim_read: burst_read_o %b want 1", burst_read_o);
        end
        for (int c = 0; c < 8; c++) begin
            if (burst_write_o === 1'b1) nwrite++;
            if (line_resp_o === 1'b1) begin
                nresp++;
                line_read_i  = 1'b0;
                line_write_i = 1'b0;
            end
            burst_rdata_i = 64'(c);
            burst_resp_i  = 1'b1;
            step();
        end
        burst_resp_i = 1'b0;
        checks++;
        if (nwrite != 0) begin
            fails++;
            $display("FAIL sim_no_write: got %0d write cycles want 0", nwrite);
        end
        checks++;
        if (nresp != 1) begin
            fails++;
            $display("FAIL sim_resp_count: got %0d want 1", nresp);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        beats[0] = 64'h0101_0101_0101_0101;
        beats[1] = 64'h0202_0202_0202_0202;
        beats[2] = 64'h0303_0303_0303_0303;
        beats[3] = 64'h0404_0404_0404_0404;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        line_addr_i  = 32'h0000_2000;
        line_wdata_i = {4{64'h7777_8888_9999_AAAA}};
        line_write_i = 1'b1;
        step();
        burst_resp_i = 1'b1;
        step();
        step();
        // Two beats accepted; reset now.
        burst_resp_i = 1'b0;
        line_write_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({line_resp_o, burst_read_o, burst_write_o} !== 3'b000 ||
            burst_addr_o !== 32'h0 || burst_wdata_o !== 64'h0 || line_rdata_o !== 256'h0) begin
            fails++;
            $display("FAIL rst_mid: resp %b rd %b wr %b addr %h wd %h rdata %h want all 0",
                     line_resp_o, burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o, line_rdata_o);
        end
        step();
        checks++;
        if (burst_write_o !== 1'b0 || burst_read_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_idle: wr %b rd %b want 0 0", burst_write_o, burst_read_o);
        end
        line_addr_i = 32'h0000_3000;
        line_read_i = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            burst_rdata_i = beats[b];
            burst_resp_i  = 1'b1;
            step();
        end
        burst_resp_i = 1'b0;
        checks++;
        if (line_resp_o !== 1'b1 || line_rdata_o !== exp_line) begin
            fails++;
            $display("FAIL rst_reread: resp %b data %h want 1 %h", line_resp_o, line_rdata_o, exp_line);
        end
        line_read_i = 1'b0;
        step();
    endtask

    task automatic test_spurious_resp();
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        logic [255:0] wd;
        int           nwrite;
        int           nresp;
        beats[0] = 64'hA0A0_A0A0_A0A0_A0A0;
        beats[1] = 64'hB1B1_B1B1_B1B1_B1B1;
        beats[2] = 64'hC2C2_C2C2_C2C2_C2C2;
        beats[3] = 64'hD3D3_D3D3_D3D3_D3D3;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        // Idle responses with no request.
        burst_resp_i  = 1'b1;
        burst_rdata_i = 64'hEEEE_EEEE_EEEE_EEEE;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({line_resp_o, burst_read_o, burst_write_o} !== 3'b000) begin
                fails++;
                $display("FAIL sp_idle%0d: got %b want 000", c, {line_resp_o, burst_read_o, burst_write_o});
            end
        end
        // Read with resp held high through IDLE and DONE.
        line_addr_i = 32'h0000_4000;
        line_read_i = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            burst_rdata_i = beats[b];
            step();
        end
        burst_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        checks++;
        if (line_resp_o !== 1'b1 || line_rdata_o !== exp_line) begin
            fails++;
            $display("FAIL sp_read: resp %b data %h want 1 %h", line_resp_o, line_rdata_o, exp_line);
        end
        line_read_i = 1'b0;
        step();
        checks++;
        if (line_resp_o !== 1'b0 || burst_read_o !== 1'b0 || line_rdata_o !== exp_line) begin
            fails++;
            $display("FAIL sp_done: resp %b read %b data %h", line_resp_o, burst_read_o, line_rdata_o);
        end
        // Write with resp still held: exactly 4 beat cycles then one completion.
        wd = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
              64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
        nwrite = 0;
        nresp  = 0;
        line_wdata_i = wd;
        line_write_i = 1'b1;
        step();
        for (int c = 0; c < 8; c++) begin
            if (burst_write_o === 1'b1) begin
                checks++;
                if (burst_wdata_o !== wd[nwrite*64 +: 64]) begin
                    fails++;
                    $display("FAIL sp_wbeat%0d: got %h want %h", nwrite, burst_wdata_o, wd[nwrite*64 +: 64]);
                end
                nwrite++;
            end
            if (line_resp_o === 1'b1) begin
                nresp++;
                line_write_i = 1'b0;
            end
            step();
        end
        burst_resp_i = 1'b0;
        checks++;
        if (nwrite != 4 || nresp != 1) begin
            fails++;
            $display("FAIL sp_write_count: beats %0d resp %0d want 4 1", nwrite, nresp);
        end
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        rst           = 1'b1;
        line_read_i   = 1'b0;
        line_write_i  = 1'b0;
        line_addr_i   = '0;
        line_wdata_i  = '0;
        burst_rdata_i = '0;
        burst_resp_i  = 1'b0;
        #1;
        test_reset();
        test_read_b2b();
        test_write();
        test_stalled_read();
        test_simultaneous();
        test_reset_mid_write();
        test_spurious_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
